// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART receiver (8N1, LSB first, idle high).
// The rxd line is synchronized, the start bit is validated at its centre, and
// each data bit and the stop bit are sampled at their centres. Completed bytes
// are presented with data-available, framing-error and overrun status.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   sample_tick one-clk pulse, OVERSAMPLE per bit period
//   rxd         asynchronous serial input, idle high
//   rd_ack      one-clk pulse: bus consumed rx_data (clears rda, overrun)
//   rx_data     last received byte
//   rda         receive data available
//   frame_err   stop bit of the last byte was sampled low
//   overrun     a byte completed while rda was still set
//   rx_busy     receiver is not idle (decoded from the state register)
module uart_receiver #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rxd,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  state_t            state_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic [7:0]        rx_data_q;
  logic              rda_q;
  logic              frame_err_q;
  logic              overrun_q;

  // Metastability synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Receive FSM, counters and bus-facing status; only rd_ack acts off-tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rda_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (rd_ack) begin
        rda_q     <= 1'b0;
        overrun_q <= 1'b0;
      end

      if (sample_tick) begin
        case (state_q)
          IDLE: begin
            if (!rx_s) begin
              state_q    <= START;
              tick_cnt_q <= '0;
            end
          end

          START: begin
            // Start-bit centre: a high line here was only a glitch.
            if (tick_cnt_q == HALF_LAST) begin
              tick_cnt_q <= '0;
              if (!rx_s) begin
                state_q   <= DATA;
                bit_cnt_q <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            end
          end

          DATA: begin
            if (tick_cnt_q == FULL_LAST) begin
              shift_q    <= {rx_s, shift_q[7:1]};
              tick_cnt_q <= '0;
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= STOP;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            end
          end

          STOP: begin
            // Leave at the stop-bit centre so a following start edge is caught.
            if (tick_cnt_q == FULL_LAST) begin
              state_q     <= IDLE;
              tick_cnt_q  <= '0;
              rx_data_q   <= shift_q;
              rda_q       <= 1'b1;
              frame_err_q <= ~rx_s;
              // A coincident rd_ack consumed the old byte, so no overrun then.
              if (rda_q && !rd_ack) begin
                overrun_q <= 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rda       = rda_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != IDLE);

endmodule
